// File: rtl/lcd_write_responder_pkg.sv
// ============================================================================
// Module   : lcd_write_responder_pkg
// Purpose  : State encodings, HD44780 command constants and helpers shared by
//            the LCD write responder and its nibble pulse generator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lcd_write_responder_pkg;

  localparam logic [3:0] c_st_init_wait = 4'd0;
  localparam logic [3:0] c_st_init_nib  = 4'd1;
  localparam logic [3:0] c_st_init_gap  = 4'd2;
  localparam logic [3:0] c_st_idle      = 4'd3;
  localparam logic [3:0] c_st_setup_h   = 4'd4;
  localparam logic [3:0] c_st_e_h       = 4'd5;
  localparam logic [3:0] c_st_gap       = 4'd6;
  localparam logic [3:0] c_st_setup_l   = 4'd7;
  localparam logic [3:0] c_st_e_l       = 4'd8;
  localparam logic [3:0] c_st_exec      = 4'd9;

  localparam logic [1:0] c_ph_idle  = 2'd0;
  localparam logic [1:0] c_ph_setup = 2'd1;
  localparam logic [1:0] c_ph_e     = 2'd2;

  localparam logic [7:0] c_cmd_clear       = 8'h01;
  localparam logic [7:0] c_cmd_home        = 8'h02;
  localparam logic [7:0] c_cmd_func_set    = 8'h28;
  localparam logic [7:0] c_cmd_entry_mode  = 8'h06;
  localparam logic [7:0] c_cmd_display_on  = 8'h0C;

  localparam logic c_rs_cmd  = 1'b0;
  localparam logic c_rs_data = 1'b1;

  localparam logic [3:0] c_init_nib_8bit = 4'h3;
  localparam logic [3:0] c_init_nib_4bit = 4'h2;

  // Clear and home need the long execution wait; everything else the short one.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return (rs == c_rs_cmd) && ((d == c_cmd_clear) || (d == c_cmd_home));
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return c_cmd_func_set;
      2'd1:    return c_cmd_entry_mode;
      2'd2:    return c_cmd_display_on;
      default: return c_cmd_clear;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_write_responder_if.sv
// ============================================================================
// Module   : lcd_write_responder_if
// Purpose  : CPU-side write handshake plus the 4-bit LCD pin bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lcd_write_responder_if;
  logic       write;
  logic       rs;
  logic [7:0] data;
  logic       ready;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [3:0] lcd_data;

  modport master (
    output write, rs, data,
    input  ready, lcd_e, lcd_rs, lcd_rw, lcd_data
  );

  modport slave (
    input  write, rs, data,
    output ready, lcd_e, lcd_rs, lcd_rw, lcd_data
  );
endinterface

`default_nettype wire

// File: rtl/lcd_nibble_pulse.sv
// ============================================================================
// Module   : lcd_nibble_pulse
// Purpose  : Presents one nibble + RS, holds setup time, then drives E high for
//            the pulse width. Data/RS persist until the next start.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_nibble_pulse
  import lcd_write_responder_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int E_PULSE_CYC = 12,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [3:0] i_nib,
  input  logic       i_rs,
  output logic       o_e,
  output logic       o_rs,
  output logic [3:0] o_data,
  output logic       o_setup_done,
  output logic       o_done
);

  localparam logic [CNT_W-1:0] c_setup_last = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_e_last     = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

  logic [1:0]       r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_nib;
  logic             r_rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= c_ph_idle;
      r_cnt   <= '0;
      r_nib   <= 4'h0;
      r_rs    <= 1'b0;
    end else begin
      case (r_phase)
        c_ph_idle: begin
          if (i_start) begin
            r_phase <= c_ph_setup;
            r_cnt   <= c_setup_last;
            r_nib   <= i_nib;
            r_rs    <= i_rs;
          end
        end
        c_ph_setup: begin
          if (r_cnt == '0) begin
            r_phase <= c_ph_e;
            r_cnt   <= c_e_last;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        c_ph_e: begin
          if (r_cnt == '0) begin
            r_phase <= c_ph_idle;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        default: begin
          r_phase <= c_ph_idle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_e          = (r_phase == c_ph_e);
  assign o_rs         = r_rs;
  assign o_data       = r_nib;
  assign o_setup_done = (r_phase == c_ph_setup) && (r_cnt == '0);
  assign o_done       = (r_phase == c_ph_e) && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lcd_write_responder.sv
// ============================================================================
// Module   : lcd_write_responder
// Purpose  : Byte-wide CPU write port driving a 4-bit HD44780 LCD, including
//            power-up init. Define LCD_AUTO_CONFIG_EN to also send the
//            0x28/0x06/0x0C/0x01 configuration bytes before the first ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_write_responder
  import lcd_write_responder_pkg::*;
#(
  parameter int PWRUP_CYC   = 750000,
  parameter int E_PULSE_CYC = 12,
  parameter int SETUP_CYC   = 2,
  parameter int NIB_GAP_CYC = 50,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000,
  parameter int CNT_W       = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lcd_write_responder_if.slave lcd_bus
);

  localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_pwrup_last   = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_gap1_last    = CNT_W'((PWRUP_CYC * 100) / 366 - 1);
  localparam logic [CNT_W-1:0] c_gap2_last    = CNT_W'(PWRUP_CYC / 150 - 1);
  localparam logic [CNT_W-1:0] c_gap3_last    = CNT_W'(PWRUP_CYC / 375 - 1);
  localparam logic [CNT_W-1:0] c_nib_gap_last = CNT_W'(NIB_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] c_exec_last    = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] c_clear_last   = CNT_W'(CLEAR_CYC - 1);

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rs;
  logic [7:0]       r_data;
  logic [1:0]       r_init_idx;

  logic [3:0]       w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_rs_nx;
  logic [7:0]       w_data_nx;
  logic [1:0]       w_init_idx_nx;
  logic             w_start;
  logic [3:0]       w_start_nib;
  logic             w_start_rs;
  logic             w_setup_done;
  logic             w_done;

`ifdef LCD_AUTO_CONFIG_EN
  logic [1:0] r_cfg_idx;
  logic       r_cfg_busy;
  logic [1:0] w_cfg_idx_nx;
  logic       w_cfg_busy_nx;
`endif

  lcd_nibble_pulse #(
    .SETUP_CYC   (SETUP_CYC),
    .E_PULSE_CYC (E_PULSE_CYC),
    .CNT_W       (CNT_W)
  ) u_pulse (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_nib        (w_start_nib),
    .i_rs         (w_start_rs),
    .o_e          (lcd_bus.lcd_e),
    .o_rs         (lcd_bus.lcd_rs),
    .o_data       (lcd_bus.lcd_data),
    .o_setup_done (w_setup_done),
    .o_done       (w_done)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_rs_nx       = r_rs;
    w_data_nx     = r_data;
    w_init_idx_nx = r_init_idx;
    w_start       = 1'b0;
    w_start_nib   = 4'h0;
    w_start_rs    = c_rs_cmd;
`ifdef LCD_AUTO_CONFIG_EN
    w_cfg_idx_nx  = r_cfg_idx;
    w_cfg_busy_nx = r_cfg_busy;
`endif
    case (r_state)
      // Counts up here so the reset value of zero starts the full power-up wait.
      c_st_init_wait: begin
        if (r_cnt == c_pwrup_last) begin
          w_start       = 1'b1;
          w_start_nib   = c_init_nib_8bit;
          w_init_idx_nx = 2'd0;
          w_cnt_nx      = '0;
          w_state_nx    = c_st_init_nib;
        end else begin
          w_cnt_nx = r_cnt + c_one;
        end
      end
      c_st_init_nib: begin
        if (w_done) begin
          w_state_nx = c_st_init_gap;
          case (r_init_idx)
            2'd0:    w_cnt_nx = c_gap1_last;
            2'd1:    w_cnt_nx = c_gap2_last;
            default: w_cnt_nx = c_gap3_last;
          endcase
        end
      end
      c_st_init_gap: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - c_one;
        end else if (r_init_idx != 2'd3) begin
          w_start       = 1'b1;
          w_start_nib   = (r_init_idx == 2'd2) ? c_init_nib_4bit : c_init_nib_8bit;
          w_init_idx_nx = r_init_idx + 2'd1;
          w_state_nx    = c_st_init_nib;
        end else begin
`ifdef LCD_AUTO_CONFIG_EN
          w_cfg_idx_nx  = 2'd0;
          w_cfg_busy_nx = 1'b1;
          w_data_nx     = cfg_byte(2'd0);
          w_rs_nx       = c_rs_cmd;
          w_start       = 1'b1;
          w_start_nib   = w_data_nx[7:4];
          w_state_nx    = c_st_setup_h;
`else
          w_state_nx    = c_st_idle;
`endif
        end
      end
      c_st_idle: begin
        if (lcd_bus.write) begin
          w_rs_nx     = lcd_bus.rs;
          w_data_nx   = lcd_bus.data;
          w_start     = 1'b1;
          w_start_nib = lcd_bus.data[7:4];
          w_start_rs  = lcd_bus.rs;
          w_state_nx  = c_st_setup_h;
        end
      end
      c_st_setup_h: begin
        if (w_setup_done) w_state_nx = c_st_e_h;
      end
      c_st_e_h: begin
        if (w_done) begin
          w_state_nx = c_st_gap;
          w_cnt_nx   = c_nib_gap_last;
        end
      end
      c_st_gap: begin
        if (r_cnt == '0) begin
          w_start     = 1'b1;
          w_start_nib = r_data[3:0];
          w_start_rs  = r_rs;
          w_state_nx  = c_st_setup_l;
        end else begin
          w_cnt_nx = r_cnt - c_one;
        end
      end
      c_st_setup_l: begin
        if (w_setup_done) w_state_nx = c_st_e_l;
      end
      c_st_e_l: begin
        if (w_done) begin
          w_state_nx = c_st_exec;
          w_cnt_nx   = is_long_cmd(r_rs, r_data) ? c_clear_last : c_exec_last;
        end
      end
      c_st_exec: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - c_one;
        end else begin
`ifdef LCD_AUTO_CONFIG_EN
          if (r_cfg_busy && (r_cfg_idx != 2'd3)) begin
            w_cfg_idx_nx = r_cfg_idx + 2'd1;
            w_data_nx    = cfg_byte(r_cfg_idx + 2'd1);
            w_rs_nx      = c_rs_cmd;
            w_start      = 1'b1;
            w_start_nib  = w_data_nx[7:4];
            w_state_nx   = c_st_setup_h;
          end else begin
            w_cfg_busy_nx = 1'b0;
            w_state_nx    = c_st_idle;
          end
`else
          w_state_nx = c_st_idle;
`endif
        end
      end
      default: begin
        w_state_nx = c_st_init_wait;
        w_cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_init_wait;
      r_cnt      <= '0;
      r_rs       <= 1'b0;
      r_data     <= 8'h00;
      r_init_idx <= 2'd0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_rs       <= w_rs_nx;
      r_data     <= w_data_nx;
      r_init_idx <= w_init_idx_nx;
    end
  end

`ifdef LCD_AUTO_CONFIG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_idx  <= 2'd0;
      r_cfg_busy <= 1'b0;
    end else begin
      r_cfg_idx  <= w_cfg_idx_nx;
      r_cfg_busy <= w_cfg_busy_nx;
    end
  end
`endif

  assign lcd_bus.ready  = (r_state == c_st_idle);
  assign lcd_bus.lcd_rw = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_responder.sv
// ============================================================================
// Module   : tb_lcd_write_responder
// Purpose  : Directed self-checking bench for lcd_write_responder (short timing
//            parameters). Honours LCD_AUTO_CONFIG_EN when defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lcd_write_responder;

  logic clk;
  logic rst_n;

  lcd_write_responder_if bus ();

  lcd_write_responder #(
    .PWRUP_CYC   (3750),
    .E_PULSE_CYC (12),
    .SETUP_CYC   (2),
    .NIB_GAP_CYC (5),
    .EXEC_CYC    (20),
    .CLEAR_CYC   (80),
    .CNT_W       (20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lcd_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int n_cyc;
  int unstable;
  int e_len;
  logic prev_e;
  logic [4:0] held;
  logic [4:0] nib_q[$];
  int rise_q[$];
  int len_q[$];

  task automatic clear_rec();
    nib_q.delete();
    rise_q.delete();
    len_q.delete();
    unstable = 0;
    n_cyc = 0;
  endtask

  // Advance one clock; sample 1 time unit after the edge and log E pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    n_cyc++;
    if (bus.lcd_e && !prev_e) begin
      held = {bus.lcd_rs, bus.lcd_data};
      nib_q.push_back(held);
      rise_q.push_back(n_cyc);
      e_len = 1;
    end else if (bus.lcd_e && prev_e) begin
      e_len++;
      if ({bus.lcd_rs, bus.lcd_data} !== held) unstable++;
    end else if (!bus.lcd_e && prev_e) begin
      len_q.push_back(e_len);
      if ({bus.lcd_rs, bus.lcd_data} !== held) unstable++;
    end
    prev_e = bus.lcd_e;
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, output int lat);
    bus.write = 1'b1;
    bus.rs    = rs;
    bus.data  = d;
    clear_rec();
    tick();
    bus.write = 1'b0;
    while (!bus.ready && n_cyc < 400) tick();
    lat = bus.ready ? n_cyc : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.write = 1'b0;
    bus.rs = 1'b0;
    bus.data = 8'h00;
    prev_e = 1'b0;
    repeat (3) tick();
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    total++; if (bus.lcd_e !== 1'b0) begin bad++; $display("FAIL reset_e: got %b want 0", bus.lcd_e); end
    total++; if (bus.lcd_rs !== 1'b0) begin bad++; $display("FAIL reset_rs: got %b want 0", bus.lcd_rs); end
    total++; if (bus.lcd_rw !== 1'b0) begin bad++; $display("FAIL reset_rw: got %b want 0", bus.lcd_rw); end
    total++; if (bus.lcd_data !== 4'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.lcd_data); end
    rst_n = 1'b1;
  endtask

  // Expects to be entered right after reset release, before the next edge.
  task automatic test_init();
    logic [4:0] exp_nib[$];
    int exp_ready;
    exp_nib = '{5'h03, 5'h03, 5'h03, 5'h02};
    exp_ready = 4875;
`ifdef LCD_AUTO_CONFIG_EN
    exp_nib.push_back(5'h02); exp_nib.push_back(5'h08);
    exp_nib.push_back(5'h00); exp_nib.push_back(5'h06);
    exp_nib.push_back(5'h00); exp_nib.push_back(5'h0C);
    exp_nib.push_back(5'h00); exp_nib.push_back(5'h01);
    exp_ready = 5147;
`endif
    clear_rec();
    while (!bus.ready && n_cyc < 8000) tick();
    total++; if (n_cyc !== exp_ready) begin bad++; $display("FAIL init_ready_cycle: got %0d want %0d", n_cyc, exp_ready); end
    total++; if (nib_q.size() !== exp_nib.size()) begin bad++; $display("FAIL init_pulse_count: got %0d want %0d", nib_q.size(), exp_nib.size()); end
    for (int i = 0; i < exp_nib.size() && i < nib_q.size(); i++) begin
      total++;
      if (nib_q[i] !== exp_nib[i]) begin bad++; $display("FAIL init_nibble[%0d]: got rs/data %h want %h", i, nib_q[i], exp_nib[i]); end
    end
    if (rise_q.size() > 0) begin
      total++; if (rise_q[0] !== 3752) begin bad++; $display("FAIL init_first_e: got cycle %0d want 3752", rise_q[0]); end
    end
    if (rise_q.size() > 3) begin
      total++; if (rise_q[1] !== 4790) begin bad++; $display("FAIL init_second_e: got cycle %0d want 4790", rise_q[1]); end
      total++; if (rise_q[3] !== 4853) begin bad++; $display("FAIL init_fourth_e: got cycle %0d want 4853", rise_q[3]); end
    end
    foreach (len_q[i]) begin
      total++;
      if (len_q[i] !== 12) begin bad++; $display("FAIL init_e_width[%0d]: got %0d want 12", i, len_q[i]); end
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL init_data_stable: got %0d glitches want 0", unstable); end
  endtask

  task automatic test_write_char();
    int lat;
    do_write(1'b1, 8'h48, lat);
    total++; if (lat !== 54) begin bad++; $display("FAIL char_latency: got %0d want 54", lat); end
    total++; if (nib_q.size() !== 2) begin bad++; $display("FAIL char_pulses: got %0d want 2", nib_q.size()); end
    if (nib_q.size() == 2) begin
      total++; if (nib_q[0] !== 5'h14) begin bad++; $display("FAIL char_high: got %h want 14", nib_q[0]); end
      total++; if (nib_q[1] !== 5'h18) begin bad++; $display("FAIL char_low: got %h want 18", nib_q[1]); end
      total++; if (rise_q[0] !== 3) begin bad++; $display("FAIL char_rise_h: got %0d want 3", rise_q[0]); end
      total++; if (rise_q[1] !== 22) begin bad++; $display("FAIL char_rise_l: got %0d want 22", rise_q[1]); end
    end
    foreach (len_q[i]) begin
      total++;
      if (len_q[i] !== 12) begin bad++; $display("FAIL char_e_width[%0d]: got %0d want 12", i, len_q[i]); end
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL char_data_stable: got %0d want 0", unstable); end
  endtask

  task automatic test_exec_wait();
    int lat;
    do_write(1'b0, 8'h01, lat);
    total++; if (lat !== 114) begin bad++; $display("FAIL clear_cmd_latency: got %0d want 114", lat); end
    do_write(1'b1, 8'h01, lat);
    total++; if (lat !== 54) begin bad++; $display("FAIL data01_latency: got %0d want 54", lat); end
    do_write(1'b0, 8'h02, lat);
    total++; if (lat !== 114) begin bad++; $display("FAIL home_cmd_latency: got %0d want 114", lat); end
    do_write(1'b0, 8'h03, lat);
    total++; if (lat !== 54) begin bad++; $display("FAIL cmd03_latency: got %0d want 54", lat); end
  endtask

  task automatic test_back_to_back();
    bus.write = 1'b1;
    bus.rs    = 1'b1;
    bus.data  = 8'hA5;
    clear_rec();
    tick();
    while (!bus.ready && n_cyc < 400) begin
      bus.data = 8'(n_cyc * 7);
      tick();
    end
    total++; if (n_cyc !== 54) begin bad++; $display("FAIL b2b_first_latency: got %0d want 54", n_cyc); end
    total++; if (nib_q.size() !== 2) begin bad++; $display("FAIL b2b_pulse_count: got %0d want 2", nib_q.size()); end
    if (nib_q.size() == 2) begin
      total++; if (nib_q[0] !== 5'h1A) begin bad++; $display("FAIL b2b_high: got %h want 1a", nib_q[0]); end
      total++; if (nib_q[1] !== 5'h15) begin bad++; $display("FAIL b2b_low: got %h want 15", nib_q[1]); end
    end
    // Strobe still high in the first ready cycle: this byte must start now.
    bus.data = 8'h3C;
    clear_rec();
    tick();
    bus.write = 1'b0;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL b2b_restart: got ready %b want 0", bus.ready); end
    while (!bus.ready && n_cyc < 400) tick();
    total++; if (n_cyc !== 54) begin bad++; $display("FAIL b2b_second_latency: got %0d want 54", n_cyc); end
    total++; if (nib_q.size() !== 2) begin bad++; $display("FAIL b2b_second_count: got %0d want 2", nib_q.size()); end
    if (nib_q.size() == 2) begin
      total++; if (nib_q[0] !== 5'h13) begin bad++; $display("FAIL b2b_second_high: got %h want 13", nib_q[0]); end
      total++; if (nib_q[1] !== 5'h1C) begin bad++; $display("FAIL b2b_second_low: got %h want 1c", nib_q[1]); end
    end
  endtask

  // Leaves reset just released so test_init can follow directly.
  task automatic test_abort();
    bus.write = 1'b1;
    bus.rs    = 1'b0;
    bus.data  = 8'h5A;
    clear_rec();
    tick();
    bus.write = 1'b0;
    while (rise_q.size() < 2 && n_cyc < 200) tick();
    repeat (3) tick();
    total++; if (bus.lcd_e !== 1'b1) begin bad++; $display("FAIL abort_in_e_l: got e %b want 1", bus.lcd_e); end
    total++; if (bus.lcd_data !== 4'hA) begin bad++; $display("FAIL abort_low_nibble: got %h want a", bus.lcd_data); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.lcd_e !== 1'b0) begin bad++; $display("FAIL abort_e_drop: got %b want 0", bus.lcd_e); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", bus.ready); end
    prev_e = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_init();
    test_write_char();
    test_exec_wait();
    test_back_to_back();
    test_abort();
    test_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
